// File: rtl/sw_pkg.sv
// Shared constants and sizing helper for the switch debounce/synchroniser block.
// Used by sw_db_bit and sw_debounce_sync (see SW_DEBOUNCE_BYPASS_EN in those files).
package sw_pkg;

    localparam int unsigned SW_WIDTH        = 16;
    localparam int unsigned SW_TICK_DIV_50M = 50000;
    localparam int unsigned SW_SAMPLES      = 4;

    // Prescaler counter width able to hold 0..tick_div-1 (at least one bit).
    function automatic int unsigned presc_width(input int unsigned tick_div);
        return (tick_div <= 2) ? 1 : $clog2(tick_div);
    endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch bit: two-flop synchroniser, tick-sampled history and debounced level.
// SW_DEBOUNCE_BYPASS_EN: history removed, db follows the synchronised level one clk later.
module sw_db_bit
    import sw_pkg::*;
#(
    parameter int unsigned SAMPLES = SW_SAMPLES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic db,
    output logic db_next_c
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

`ifdef SW_DEBOUNCE_BYPASS_EN
    logic unused_tick;
    assign unused_tick = tick;
    assign db_next_c   = sync[1];
`else
    logic [SAMPLES-1:0] hist;
    logic [SAMPLES-1:0] hist_next;

    // Level changes only when every sample in the updated window agrees.
    always_comb begin
        hist_next = {hist[SAMPLES-2:0], sync[1]};
        db_next_c = db;
        if (tick) begin
            if (&hist_next) begin
                db_next_c = 1'b1;
            end else if (~|hist_next) begin
                db_next_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (tick) begin
            hist <= hist_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db <= 1'b0;
        end else begin
            db <= db_next_c;
        end
    end

endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronise and debounce the slide switches, publish changes through valid/ready.
// SW_DEBOUNCE_BYPASS_EN: prescaler removed, bits pass straight from the synchronisers.
module sw_debounce_sync
    import sw_pkg::*;
#(
    parameter int unsigned WIDTH    = SW_WIDTH,
    parameter int unsigned TICK_DIV = SW_TICK_DIV_50M,
    parameter int unsigned SAMPLES  = SW_SAMPLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             upd_ready,
    output logic             upd_valid,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_mask,
    output logic [WIDTH-1:0] fall_mask,
    output logic [WIDTH-1:0] sw_db
);

    logic             tick;
    logic [WIDTH-1:0] db_next;

`ifdef SW_DEBOUNCE_BYPASS_EN
    assign tick = 1'b0;
`else
    localparam int unsigned CW = presc_width(TICK_DIV);

    logic [CW-1:0] presc;

    assign tick = (presc == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + CW'(1);
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_db_bit #(
            .SAMPLES(SAMPLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .raw      (sw_raw[i]),
            .db       (sw_db[i]),
            .db_next_c(db_next[i])
        );
    end

    logic [WIDTH-1:0] pend_rise;
    logic [WIDTH-1:0] pend_fall;
    logic [WIDTH-1:0] new_rise;
    logic [WIDTH-1:0] new_fall;
    logic             pend_any;
    logic             load;

    assign new_rise = db_next & ~sw_db;
    assign new_fall = ~db_next & sw_db;
    assign pend_any = |(pend_rise | pend_fall);
    assign load     = pend_any && (!upd_valid || upd_ready);

    // Load snapshot when the output slot is free or being taken; changes arriving
    // on the load edge start the next pending set so none are lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid <= 1'b0;
            sw_out    <= '0;
            rise_mask <= '0;
            fall_mask <= '0;
            pend_rise <= '0;
            pend_fall <= '0;
        end else if (load) begin
            upd_valid <= 1'b1;
            sw_out    <= sw_db;
            rise_mask <= pend_rise;
            fall_mask <= pend_fall;
            pend_rise <= new_rise;
            pend_fall <= new_fall;
        end else begin
            pend_rise <= pend_rise | new_rise;
            pend_fall <= pend_fall | new_fall;
            if (upd_ready) begin
                upd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Randomised and directed bench for sw_debounce_sync with a sample-window reference model.
module tb_sw_debounce_sync;

    localparam int unsigned W  = 16;
    localparam int unsigned TD = 4;
    localparam int unsigned NS = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic         upd_ready = 1'b1;
    logic         upd_valid;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise_mask;
    logic [W-1:0] fall_mask;
    logic [W-1:0] sw_db;

    sw_debounce_sync #(
        .WIDTH   (W),
        .TICK_DIV(TD),
        .SAMPLES (NS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .upd_ready(upd_ready),
        .upd_valid(upd_valid),
        .sw_out   (sw_out),
        .rise_mask(rise_mask),
        .fall_mask(fall_mask),
        .sw_db    (sw_db)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned valid_seen = 0;
    int unsigned xfers = 0;
    logic [W-1:0] last_out, last_rise, last_fall;

    // Reference model: raw levels in flight through the synchroniser, the last NS
    // tick samples, and the published/pending change sets.
    logic [W-1:0] raw_q[$];
    logic [W-1:0] smp_q[$];
    int unsigned  edge_n;
    logic [W-1:0] m_db, m_out, m_rise, m_fall, m_prise, m_pfall;
    logic         m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q = {};
        raw_q.push_back('0);
        raw_q.push_back('0);
        smp_q = {};
        repeat (NS) smp_q.push_back('0);
        edge_n  = 0;
        m_db    = '0;
        m_out   = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_prise = '0;
        m_pfall = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, db_n, nr, nf;
        s = raw_q.pop_front();
        raw_q.push_back(sw_raw);
        db_n = m_db;
        if (edge_n % TD == TD - 1) begin
            void'(smp_q.pop_front());
            smp_q.push_back(s);
            for (int b = 0; b < W; b++) begin
                int unsigned ones;
                ones = 0;
                foreach (smp_q[k]) ones += smp_q[k][b];
                if (ones == NS) db_n[b] = 1'b1;
                else if (ones == 0) db_n[b] = 1'b0;
            end
        end
        nr = db_n & ~m_db;
        nf = m_db & ~db_n;
        if ((m_prise | m_pfall) != '0 && (!m_valid || upd_ready)) begin
            m_out   = m_db;
            m_rise  = m_prise;
            m_fall  = m_pfall;
            m_valid = 1'b1;
            m_prise = nr;
            m_pfall = nf;
        end else begin
            if (m_valid && upd_ready) m_valid = 1'b0;
            m_prise |= nr;
            m_pfall |= nf;
        end
        m_db = db_n;
        edge_n++;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("upd_valid", 32'(upd_valid), 32'(m_valid));
            check("sw_db", 32'(sw_db), 32'(m_db));
            check("sw_out", 32'(sw_out), 32'(m_out));
            check("rise_mask", 32'(rise_mask), 32'(m_rise));
            check("fall_mask", 32'(fall_mask), 32'(m_fall));
            if (upd_valid) valid_seen++;
            if (upd_valid && upd_ready) begin
                xfers++;
                last_out  = sw_out;
                last_rise = rise_mask;
                last_fall = fall_mask;
            end
        end
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned k;
        k = 0;
        while (!upd_valid && k < budget) begin
            run(1);
            k++;
        end
        check("wait_valid", 32'(upd_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    logic [W-1:0] base;
    int unsigned  r;

    initial begin
        // Reset state and idle behaviour
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(upd_valid), 32'd0);
        check("rst_out", 32'(sw_out), 32'd0);
        check("rst_rise", 32'(rise_mask), 32'd0);
        check("rst_fall", 32'(fall_mask), 32'd0);
        check("rst_db", 32'(sw_db), 32'd0);
        model_reset();
        reset = 1'b1;
        valid_seen = 0;
        run(200);
        check("idle_valid_seen", valid_seen, 32'd0);

        // Clean edge on two bits produces exactly one rising update
        xfers = 0;
        sw_raw = 16'h8001;
        run(22);
        check("db_8001", 32'(sw_db), 32'h8001);
        run(10);
        check("xfers_8001", xfers, 32'd1);
        check("xfer_out", 32'(last_out), 32'h8001);
        check("xfer_rise", 32'(last_rise), 32'h8001);
        check("xfer_fall", 32'(last_fall), 32'd0);

        // Bouncing bit 3 never debounces high
        valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) sw_raw = sw_raw ^ 16'h0008;
            run(1);
        end
        sw_raw = 16'h8001;
        run(30);
        check("bounce_valid_seen", valid_seen, 32'd0);
        check("bounce_db3", 32'(sw_db[3]), 32'd0);

        // Backpressure freezes outputs; back-to-back reload on transfer
        sw_raw = '0;
        do_reset();
        upd_ready = 1'b0;
        sw_raw = 16'h0001;
        run(30);
        check("bp_valid", 32'(upd_valid), 32'd1);
        check("bp_out", 32'(sw_out), 32'h0001);
        sw_raw = 16'h0021;
        run(30);
        check("bp_frozen", 32'(sw_out), 32'h0001);
        upd_ready = 1'b1;
        run(1);
        check("b2b_out", 32'(sw_out), 32'h0021);
        check("b2b_rise", 32'(rise_mask), 32'h0020);
        check("b2b_valid", 32'(upd_valid), 32'd1);
        run(1);

        // Rise presented, then fall accumulates behind it
        upd_ready = 1'b0;
        sw_raw = 16'h0025;
        run(30);
        check("rf_rise", 32'(rise_mask), 32'h0004);
        check("rf_out1", 32'(sw_out), 32'h0025);
        sw_raw = 16'h0021;
        run(30);
        upd_ready = 1'b1;
        run(1);
        check("rf_out2", 32'(sw_out), 32'h0021);
        check("rf_fall", 32'(fall_mask), 32'h0004);
        check("rf_rise2", 32'(rise_mask), 32'h0000);
        run(3);

        // Reset while an update is pending clears outputs without a clock edge
        upd_ready = 1'b0;
        sw_raw = '0;
        run(30);
        check("pre_rst_valid", 32'(upd_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("async_valid", 32'(upd_valid), 32'd0);
        check("async_out", 32'(sw_out), 32'd0);
        check("async_rise", 32'(rise_mask), 32'd0);
        check("async_fall", 32'(fall_mask), 32'd0);
        model_reset();
        sw_raw = 16'h00F0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        upd_ready = 1'b1;
        wait_valid(60);
        check("post_rst_rise", 32'(rise_mask), 32'h00F0);
        check("post_rst_out", 32'(sw_out), 32'h00F0);
        check("post_rst_fall", 32'(fall_mask), 32'd0);

        // Random slow changes, single-cycle glitches and random backpressure
        base = sw_raw;
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            upd_ready = ($urandom_range(0, 3) != 0);
            if (r < 3) base = base ^ (W'(1) << $urandom_range(0, W - 1));
            sw_raw = base;
            if (r >= 3 && r < 6) sw_raw = base ^ (W'(1) << $urandom_range(0, W - 1));
            run(1);
        end
        upd_ready = 1'b1;
        sw_raw = base;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
